// File: rtl/regfile_pkg.sv
// Shared types and constants for the write-back register file.
package regfile_pkg;

    localparam int unsigned DATA_W     = 64;
    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [4:0]  ZR_IDX     = 5'd31;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]     word_t;

endpackage

// File: rtl/reg_en.sv
// Single storage register with write enable and asynchronous active-low clear.
module reg_en #(
    parameter int unsigned W = regfile_pkg::DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// Architectural register file: one write port from write-back, two combinational
// read ports with write-through bypass; the top index reads as zero (XZR).
module regfile_wb #(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned NREG   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [4:0]        WB_destReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [4:0]        Rn,
    input  logic [4:0]        Rm,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    import regfile_pkg::*;

    logic [NREG-2:0]   we;
    logic [DATA_W-1:0] regs [NREG];
    logic              byp1;
    logic              byp2;

    for (genvar i = 0; i < NREG - 1; i++) begin : g_regs
        assign we[i] = RegWrite && (WB_destReg == reg_idx_t'(i));

        reg_en #(
            .W(DATA_W)
        ) u_reg (
            .clk  (clk),
            .reset(reset),
            .en   (we[i]),
            .d    (WriteData),
            .q    (regs[i])
        );
    end

    // XZR has no storage; its mux slot is a constant zero.
    assign regs[NREG-1] = '0;

    // XZR wins over bypass, so the bypass is suppressed for the zero index.
    assign byp1 = RegWrite && (WB_destReg == Rn) && (Rn != ZR_IDX);
    assign byp2 = RegWrite && (WB_destReg == Rm) && (Rm != ZR_IDX);

    always_comb begin
        ReadData1 = regs[Rn];
        ReadData2 = regs[Rm];
        if (byp1) begin
            ReadData1 = WriteData;
        end
        if (byp2) begin
            ReadData2 = WriteData;
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed plus randomized bench for regfile_wb against an array-based model.
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WB_destReg;
    logic [63:0] WriteData;
    logic [4:0]  Rn;
    logic [4:0]  Rm;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int unsigned total  = 0;
    int unsigned passed = 0;

    logic [63:0] model [32];

    always #5 clk = ~clk;

    regfile_wb #(
        .DATA_W(64),
        .NREG  (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .WB_destReg(WB_destReg),
        .WriteData (WriteData),
        .Rn        (Rn),
        .Rm        (Rm),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2)
    );

    function automatic logic [63:0] expect_read(input logic [4:0] idx);
        if (idx == 5'd31) return 64'd0;
        if (RegWrite && WB_destReg == idx) return WriteData;
        return model[idx];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic we, input logic [4:0] dst, input logic [63:0] d,
                         input logic [4:0] rn, input logic [4:0] rm);
        RegWrite   = we;
        WB_destReg = dst;
        WriteData  = d;
        Rn         = rn;
        Rm         = rm;
        #1;
    endtask

    task automatic check_ports(input string tag);
        chk({tag, "_rd1"}, ReadData1, expect_read(Rn));
        chk({tag, "_rd2"}, ReadData2, expect_read(Rm));
    endtask

    // Advance one rising edge, applying the write rule to the model.
    task automatic tick();
        logic        we_s;
        logic [4:0]  dst_s;
        logic [63:0] d_s;
        we_s  = RegWrite;
        dst_s = WB_destReg;
        d_s   = WriteData;
        @(posedge clk);
        if (reset && we_s && dst_s != 5'd31) model[dst_s] = d_s;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
    endtask

    initial begin
        clear_model();
        for (int i = 0; i < 32; i++) model[i] = 64'hDEAD_0000_0000_0000 | 64'(i);
        reset = 1'b0;
        drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
        clear_model();

        // Reset: clock while held low, release, then read every index.
        tick();
        tick();
        #2 reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i));
            chk("reset_rd1", ReadData1, 64'd0);
            chk("reset_rd2", ReadData2, 64'd0);
        end

        // Write/readback.
        drive(1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 5'd5, 5'd6);
        tick();
        drive(1'b0, 5'd5, 64'd0, 5'd5, 5'd6);
        chk("wr_x5", ReadData1, 64'h0123_4567_89AB_CDEF);
        chk("wr_x6", ReadData2, 64'd0);

        // XZR: write to 31 dropped, reads zero before and after the edge.
        drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd5);
        chk("xzr_pre", ReadData1, 64'd0);
        chk("xzr_pre_x5", ReadData2, 64'h0123_4567_89AB_CDEF);
        tick();
        chk("xzr_post", ReadData1, 64'd0);
        for (int i = 0; i < 31; i++) begin
            drive(1'b0, 5'd0, 64'd0, 5'(i), 5'd31);
            chk("xzr_others", ReadData1, (i == 5) ? 64'h0123_4567_89AB_CDEF : 64'd0);
        end

        // Bypass.
        drive(1'b1, 5'd9, 64'h10, 5'd9, 5'd9);
        tick();
        drive(1'b1, 5'd9, 64'h20, 5'd9, 5'd9);
        chk("byp_rd1", ReadData1, 64'h20);
        chk("byp_rd2", ReadData2, 64'h20);
        drive(1'b0, 5'd9, 64'h20, 5'd9, 5'd9);
        chk("nobyp_rd1", ReadData1, 64'h10);
        chk("nobyp_rd2", ReadData2, 64'h10);
        drive(1'b1, 5'd9, 64'h20, 5'd9, 5'd9);
        tick();
        drive(1'b0, 5'd0, 64'd0, 5'd9, 5'd9);
        chk("byp_post_rd1", ReadData1, 64'h20);
        chk("byp_post_rd2", ReadData2, 64'h20);

        // Disabled write across three edges.
        drive(1'b1, 5'd3, 64'h33, 5'd3, 5'd3);
        tick();
        drive(1'b0, 5'd3, 64'hAA, 5'd3, 5'd3);
        tick();
        tick();
        tick();
        chk("dis_x3", ReadData1, 64'h33);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                  {$urandom, $urandom}, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            check_ports("rand_pre");
            tick();
            check_ports("rand_post");
        end

        // Async reset between edges; a write presented during reset is lost.
        drive(1'b1, 5'd1, 64'h77, 5'd1, 5'd2);
        tick();
        drive(1'b0, 5'd0, 64'd0, 5'd1, 5'd2);
        chk("ar_x1_stored", ReadData1, 64'h77);
        drive(1'b1, 5'd2, 64'h55, 5'd1, 5'd4);
        reset = 1'b0;
        clear_model();
        #1;
        chk("ar_x1_cleared", ReadData1, 64'd0);
        tick();
        #2 reset = 1'b1;
        drive(1'b0, 5'd2, 64'd0, 5'd2, 5'd1);
        chk("ar_x2_lost", ReadData1, 64'd0);
        chk("ar_x1_zero", ReadData2, 64'd0);

        // First edge after release performs a normal write.
        drive(1'b1, 5'd7, 64'hCAFE, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 64'd0, 5'd7, 5'd2);
        chk("post_rst_wr", ReadData1, 64'hCAFE);
        check_ports("post_rst_model");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Architectural register file for the pipelined ARM CPU, sitting at the write-back/decode boundary. Accepts the write-back stage's result (`WriteData`) and destination index (`WB_destReg`) as its write port. Serves two combinational read ports to decode, with write-through bypass so decode sees a same-cycle write-back value. X31 is hardwired zero (XZR).

## Interface
Parameters:
- `DATA_W`, 64, register width
- `NREG`, 32, number of architectural registers (index `NREG-1` is XZR)

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset; clears all registers while low
- `RegWrite`  in  1  write enable from write-back control
- `WB_destReg`  in  5  write index
- `WriteData`  in  DATA_W  write value from write-back stage
- `Rn`  in  5  read port 1 index
- `Rm`  in  5  read port 2 index
- `ReadData1`  out  DATA_W  value of register `Rn`
- `ReadData2`  out  DATA_W  value of register `Rm`

## Operation
- Storage: registers X0..X30, each DATA_W bits. X31 has no storage.
- Write:
  - On rising `clk` with `reset` high and `RegWrite`=1 and `WB_destReg`≠31: `X[WB_destReg]` ← `WriteData`.
  - Writes to index 31 are dropped.
  - `RegWrite`=0 leaves all registers unchanged.
- Read (combinational, independent ports):
  - If index = 31: output 0.
  - Else if `RegWrite`=1 and `WB_destReg` = index: output `WriteData` (bypass).
  - Else: output the stored `X[index]`.
- Bypass priority: bypass beats stored value; XZR beats bypass.
- Both ports may address the same register; each resolves identically.

## Timing
- Reset:
  - `reset` low clears X0..X30 to 0 asynchronously, without waiting for a clock edge.
  - Outputs follow the read rules, so they read 0 unless bypassed.
  - A write request while `reset` is low is lost.
  - After `reset` deasserts, the first rising edge performs a normal write.
- Write latency:
  - One edge: a value written at edge N is held in storage from N onward.
  - The same value is visible on the read ports combinationally during the cycle before edge N, via bypass.
- Read latency: zero cycles (combinational from `Rn`/`Rm`/`RegWrite`/`WB_destReg`/`WriteData`).
- Back-to-back writes to the same index: the last edge wins. No hazard on the read side, because bypass always shows the pending value.
- Reset asserted mid-cycle overrides any pending write.

## Structure
- Package `regfile_pkg`:
  - `DATA_W` = 64
  - `REG_ADDR_W` = 5
  - `ZR_IDX` = 5'd31
  - typedef `reg_idx_t` (logic [4:0])
  - typedef `word_t` (logic [63:0])
- Sub-module `reg_en`: one DATA_W register with write enable and asynchronous active-low clear.
  - Instantiated 31 times.
  - Each enable comes from a 5:32 decode of `WB_destReg` gated by `RegWrite`, with bit 31 unused.
- Read path per port:
  - 32:1 selection over stored values (slot 31 = 0).
  - Followed by a 2:1 bypass select, with the bypass condition forced false when the index is 31.

## Test plan
- Reset: hold `reset` low, then release; read all 32 indices on both ports -> every read is 0.
- Write/readback: write X5=0x0123_4567_89AB_CDEF at one edge, then `RegWrite`=0; `Rn`=5 -> `ReadData1`=0x0123_4567_89AB_CDEF; `Rm`=6 -> 0.
- XZR:
  - write X31=0xFFFF_FFFF_FFFF_FFFF with `RegWrite`=1 -> `ReadData1` for `Rn`=31 is 0 in the same cycle and after the edge.
  - No other register changes.
- Bypass:
  - X9=0x10 stored; drive `RegWrite`=1, `WB_destReg`=9, `WriteData`=0x20, `Rn`=`Rm`=9 -> both ports read 0x20 before the edge.
  - With `RegWrite`=0 the ports read 0x10 before the edge.
  - After the edge, both read 0x20.
- Disabled write: `RegWrite`=0, `WB_destReg`=3, `WriteData`=0xAA across 3 edges -> X3 stays at its prior value.
- Async reset mid-operation:
  - write X1=0x77; in the next cycle assert `reset` low between edges -> `ReadData1`(`Rn`=1) goes to 0 before any clock edge.
  - A write presented during reset is not stored.
